// File: rtl/sap_prog_mem_pkg.sv
// sap_pkg: shared definitions for the SAP program/data memory.
//   - SAP opcode constants used to spell out the built-in demo program
//   - load-controller state enum (RUN, LOAD)
//   - default_word(): reset-image word for a given address
package sap_pkg;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic {
        RUN  = 1'b0,
        LOAD = 1'b1
    } ld_state_t;

    // Demo program: LDA 9; ADD A; ADD B; SUB C; OUT; HLT; data at 9..12.
    // Addresses outside the image (including beyond 15 on wider builds) read 0.
    function automatic logic [7:0] default_word(input int unsigned addr);
        logic [7:0] w;
        case (addr)
            0:       w = {OP_LDA, 4'h9};
            1:       w = {OP_ADD, 4'hA};
            2:       w = {OP_ADD, 4'hB};
            3:       w = {OP_SUB, 4'hC};
            4:       w = {OP_OUT, 4'h0};
            5:       w = {OP_HLT, 4'h0};
            9:       w = 8'h10;
            10:      w = 8'h14;
            11:      w = 8'h18;
            12:      w = 8'h20;
            default: w = 8'h00;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/sap_load_ctrl.sv
// sap_load_ctrl: streaming-loader controller for sap_prog_mem.
//   state | meaning
//   RUN   | normal operation, reads accepted, loader not ready
//   LOAD  | burst in progress, ld_ready=1, each transfer writes mem[ptr]
// Ports:
//   clk, rst_n              clock, async active-low reset
//   ld_start/valid/last     loader handshake inputs
//   ld_ready, ld_busy       high while in LOAD (taken straight from the state flop)
//   ld_done                 registered one-cycle pulse after a burst ends
//   wr_en, wr_addr          array write strobe and address for the top
module sap_load_ctrl
    import sap_pkg::*;
#(
    parameter int ADDR_W    = 4,
    parameter int LOAD_BASE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              ld_busy,
    output logic              ld_done,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr
);

    localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(LOAD_BASE);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    ld_state_t         state;
    logic [ADDR_W-1:0] ptr;

    assign ld_ready = (state == LOAD);
    assign ld_busy  = (state == LOAD);
    assign wr_en    = ld_valid & ld_ready;
    assign wr_addr  = ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RUN;
            ptr     <= BASE_ADDR;
            ld_done <= 1'b0;
        end else begin
            ld_done <= 1'b0;
            // ld_start wins over a coincident final transfer: the word is still
            // written (wr_en is combinational) but the burst restarts silently.
            if (ld_start) begin
                state <= LOAD;
                ptr   <= BASE_ADDR;
            end else if (state == LOAD && ld_valid) begin
                if (ld_last || ptr == LAST_ADDR) begin
                    state   <= RUN;
                    ld_done <= 1'b1;
                end else begin
                    ptr <= ptr + ADDR_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/sap_prog_mem.sv
// sap_prog_mem: clocked program/data memory for the SAP-class CPU.
// Flop-based array reset to the built-in demo program, a registered read port
// (1-cycle latency) and a streaming loader port driven by sap_load_ctrl.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   rd_req, rd_addr     read request/address (accepted only in RUN, not on ld_start)
//   rd_data, rd_valid   registered read data and one-cycle valid
//   ld_start, ld_valid, ld_data, ld_last, ld_ready, ld_busy, ld_done   loader
// Optional build macro SAP_PROG_MEM_PARITY_EN adds a stored even-parity bit per
// word, output rd_perr (registered with rd_data) and input inj_perr (inverts the
// parity written on a load transfer).
module sap_prog_mem
    import sap_pkg::*;
#(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 8,
    parameter int LOAD_BASE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              ld_busy,
    output logic              ld_done
`ifdef SAP_PROG_MEM_PARITY_EN
    ,
    output logic              rd_perr,
    input  logic              inj_perr
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              rd_accept;

    sap_load_ctrl #(
        .ADDR_W    (ADDR_W),
        .LOAD_BASE (LOAD_BASE)
    ) u_load_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .ld_start (ld_start),
        .ld_valid (ld_valid),
        .ld_last  (ld_last),
        .ld_ready (ld_ready),
        .ld_busy  (ld_busy),
        .ld_done  (ld_done),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr)
    );

    // Reads are only taken in RUN and never on the ld_start edge, so a read
    // and a load write can never hit the array in the same cycle.
    assign rd_accept = rd_req & ~ld_busy & ~ld_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= DATA_W'(default_word(i));
            end
        end else if (wr_en) begin
            mem[wr_addr] <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_accept;
            if (rd_accept) begin
                rd_data <= mem[rd_addr];
            end
        end
    end

`ifdef SAP_PROG_MEM_PARITY_EN
    logic par_mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                par_mem[i] <= ^(DATA_W'(default_word(i)));
            end
        end else if (wr_en) begin
            par_mem[wr_addr] <= (^ld_data) ^ inj_perr;
        end
    end

    // Follows rd_valid: only flags a mismatch on an accepted read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_perr <= 1'b0;
        end else begin
            rd_perr <= rd_accept & ((^mem[rd_addr]) ^ par_mem[rd_addr]);
        end
    end
`endif

endmodule

// File: doc/sap_prog_mem.md
Name: sap_prog_mem

Overview:
- Parametrised, clocked program/data memory for the SAP-class CPU; replaces the fixed combinational 16x8 program store.
- Presents a registered read port to the fetch/operand path.
- Adds a streaming loader port, so a new program can be written in without resynthesis.
- Comes out of reset holding the built-in demo program; it sits between the memory-address register and the W-bus.

Parameters:
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W words.
- DATA_W, 8, word width; must be >= 8. Words wider than 8 are zero-extended from the default image.
- LOAD_BASE, 0, first address written by a load burst (must be < DEPTH).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- rd_req  in  1  read request, sampled at clk.
- rd_addr  in  ADDR_W  read address.
- rd_data  out  DATA_W  registered read data.
- rd_valid  out  1  rd_data valid, one-cycle pulse.
- ld_start  in  1  begin load burst (pulse).
- ld_valid  in  1  loader word present.
- ld_data  in  DATA_W  loader word.
- ld_last  in  1  final word of burst, qualified by ld_valid.
- ld_ready  out  1  loader may transfer; transfer = ld_valid & ld_ready.
- ld_busy  out  1  high in LOAD state.
- ld_done  out  1  one-cycle pulse when a burst completes.

Behaviour:
- Reset (async assert, sync-safe deassert): FSM=RUN; rd_data=0; rd_valid=0; ld_ready=0; ld_busy=0; ld_done=0; load pointer=LOAD_BASE.
- Reset memory image: addr0=0x09, 1=0x1A, 2=0x1B, 3=0x2C, 4=0xE0, 5=0xF0, 9=0x10, 10=0x14, 11=0x18, 12=0x20; all other words 0.
- The array is therefore flop-based and reset to this image.
- FSM states: RUN, LOAD.
- RUN -> LOAD: on ld_start. The pointer is loaded with LOAD_BASE in the same edge.
- LOAD -> RUN, on whichever comes first:
  - a transfer with ld_last=1;
  - a transfer at pointer==DEPTH-1.
  - On either exit, ld_done pulses high for exactly one cycle after that edge.
- LOAD: ld_ready=1 and ld_busy=1. Each transfer writes mem[ptr] <= ld_data and increments ptr. The pointer never wraps; the burst is ended at DEPTH-1.
- ld_start while already in LOAD restarts the burst:
  - pointer returns to LOAD_BASE;
  - words already written are kept;
  - no ld_done pulse.
- ld_start coinciding with a final transfer: the final word is written and the FSM stays in LOAD with the pointer reset; no ld_done.
- Read, RUN state: rd_req at edge N gives rd_data=mem[rd_addr] and rd_valid=1 after edge N. Latency is 1 cycle; back-to-back reads are allowed every cycle.
- Read, LOAD state or the ld_start cycle: the request is dropped (rd_valid=0) and rd_data holds its last value.
- Read-during-write is impossible by construction.
- rd_valid is low on any cycle without an accepted request; rd_data holds.
- Reset mid-burst: the burst is aborted, the image is restored and ld_done does not pulse.
- rd_addr is always in range; DEPTH is a power of two.

Optional Feature:
- Macro: SAP_PROG_MEM_PARITY_EN.
- Defined:
  - each word stores an extra even-parity bit, computed on load writes and on the reset image;
  - extra output rd_perr (1 bit) is registered alongside rd_data and asserts with rd_valid when the stored parity mismatches;
  - extra input inj_perr (1 bit) inverts the parity bit written on a load transfer, for test.
- Undefined: no parity storage and no rd_perr/inj_perr ports.

Decomposition:
- Package sap_pkg:
  - opcode constants OP_LDA=4'h0, OP_ADD=4'h1, OP_SUB=4'h2, OP_OUT=4'hE, OP_HLT=4'hF;
  - the state enum {RUN, LOAD};
  - a function returning the default image word for an address.
- One sub-module, sap_load_ctrl: FSM, pointer, ld_ready/ld_busy/ld_done, write-enable and write-address generation.
- The array and the read register stay in the top.

Test Plan:
- Reset then read addr 0..15 back-to-back → rd_valid every cycle, 1-cycle latency, data 09,1A,1B,2C,E0,F0,00,00,00,10,14,18,20,00,00,00.
- Load burst of 3 words (0x0F, 0x1F, 0xE0, ld_last on the 3rd) with ld_valid gaps → ld_done one pulse, ld_busy low next cycle; reads 0..3 give 0F,1F,E0,2C.
- Burst of 20 words with no ld_last at DEPTH=16 → words 0..15 written, ld_done after the 16th, ld_ready=0 for words 17..20; read 15 = 16th word.
- rd_req asserted throughout a load → rd_valid=0 for all LOAD cycles and rd_data unchanged; reads resume 1 cycle after return to RUN.
- ld_start mid-burst after 2 words, then 1 word 0xAA with ld_last → addr0=0xAA, addr1 keeps 2nd word, single ld_done; async rst_n pulse mid-burst → image restored, no ld_done.
- SAP_PROG_MEM_PARITY_EN: load 0x01 with inj_perr=1 then read it → rd_perr=1; reset-image reads → rd_perr=0.
